// File: rtl/freq_div_pkg.sv
// Shared definitions for the frequency-divider controller and its datapath:
// controller state codes, divider state encoding and default sizing.
package freq_div_pkg;

  // Default width of K and of the period counter
  localparam int W_DEFAULT = 16;

  // Default dividend; must stay below 2**W_DEFAULT
  localparam int REF_COUNT_DEFAULT = 50000;

  // Controller state codes, shared with the controller
  localparam logic [2:0] ST_IDLE     = 3'b000;
  localparam logic [2:0] ST_STARTING = 3'b001;
  localparam logic [2:0] ST_CALC_K   = 3'b010;
  localparam logic [2:0] ST_CNT_LOAD = 3'b011;
  localparam logic [2:0] ST_COUNTING = 3'b100;

  // Divider sequencing states
  typedef enum logic [1:0] {
    D_IDLE = 2'b00,
    D_BUSY = 2'b01,
    D_DONE = 2'b10
  } div_state_e;

endpackage

// File: rtl/freq_div_datapath_if.sv
// Handshake bundle between the frequency-divider controller (master) and
// the datapath responder (slave).
interface freq_div_datapath_if
  import freq_div_pkg::*;
#(
  parameter int W = W_DEFAULT
);

  logic [7:0]   n_in;       // requested divisor from the switches
  logic [2:0]   cur_state;  // controller state code
  logic         LdCnt;      // load the period counter
  logic         counten;    // advance the period counter
  logic         valid;      // square-wave output enabled
  logic         kcalc;      // K ready (level)
  logic         cout;       // period terminal count (combinational)
  logic [W-1:0] k_out;      // last computed K
  logic         wave;       // divided square wave

  modport master (
    output n_in, cur_state, LdCnt, counten, valid,
    input  kcalc, cout, k_out, wave
  );

  modport slave (
    input  n_in, cur_state, LdCnt, counten, valid,
    output kcalc, cout, k_out, wave
  );

endinterface

// File: rtl/k_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, MSB first.
// 'done' flags the cycle whose step produces the final quotient, and
// 'quotient' carries that step's result so the caller can capture it on
// the same edge that finishes the division. A zero divisor finishes
// after a single step; the caller is expected to override the result.
module k_divider
  import freq_div_pkg::*;
#(
  parameter int W  = W_DEFAULT,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  dividend,
  input  logic [DW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  quotient
);

  localparam int             IW       = $clog2(W);
  localparam logic [IW-1:0]  IDX_LAST = IW'(W - 1);
  localparam logic [IW-1:0]  IDX_ONE  = IW'(1);

  logic          r_busy;
  logic [IW-1:0] r_idx;
  logic [DW-1:0] r_rem;
  logic [W-1:0]  r_quo;

  logic [DW:0]   w_shift;
  logic [DW:0]   w_diff;
  logic          w_fits;
  logic [DW-1:0] w_rem_next;
  logic [W-1:0]  w_quo_next;

  // One restoring step: bring in the next dividend bit, subtract if it fits
  always_comb begin
    w_shift    = {r_rem, r_quo[W-1]};
    w_diff     = w_shift - {1'b0, divisor};
    w_fits     = (w_shift >= {1'b0, divisor});
    w_rem_next = DW'(w_fits ? w_diff : w_shift);
    w_quo_next = {r_quo[W-2:0], w_fits};
  end

  assign done     = r_busy && ((r_idx == '0) || (divisor == '0));
  assign busy     = r_busy;
  assign quotient = w_quo_next;

  // Load operands on start (a restart overrides a division in flight),
  // otherwise step once per cycle while busy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_idx  <= '0;
      r_rem  <= '0;
      r_quo  <= '0;
    end else if (start) begin
      r_busy <= 1'b1;
      r_idx  <= IDX_LAST;
      r_rem  <= '0;
      r_quo  <= dividend;
    end else if (r_busy) begin
      r_rem <= w_rem_next;
      r_quo <= w_quo_next;
      if (done) begin
        r_busy <= 1'b0;
      end else begin
        r_idx <= r_idx - IDX_ONE;
      end
    end
  end

endmodule

// File: rtl/freq_div_datapath.sv
// Datapath responder for the frequency-divider controller. Computes
// K = REF_COUNT / n with a multi-cycle divider while the controller sits
// in CALC_K, then drives the loadable period counter and the square wave.
module freq_div_datapath
  import freq_div_pkg::*;
#(
  parameter int W         = W_DEFAULT,
  parameter int REF_COUNT = REF_COUNT_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  freq_div_datapath_if.slave  bus
);

  localparam logic [W-1:0] DIVIDEND = W'(REF_COUNT);
  localparam logic [W-1:0] ONE      = W'(1);
  localparam logic [W-1:0] ALL_ONES = {W{1'b1}};

  div_state_e   r_dstate;
  div_state_e   w_dstate_next;
  logic [7:0]   r_n_q;
  logic [W-1:0] r_k_out;
  logic [W-1:0] r_cnt;
  logic         r_wave;

  logic         w_calc;
  logic         w_start;
  logic         w_k_load;
  logic [W-1:0] w_k_new;
  logic         w_div_busy;
  logic         w_div_done;
  logic [W-1:0] w_quotient;
  logic         w_cout;

  // Divide-by-zero saturates to the largest K; a zero quotient would stall
  // the period counter, so it is raised to 1
  function automatic logic [W-1:0] clamp_k(input logic [7:0] n, input logic [W-1:0] q);
    logic [W-1:0] k;
    if (n == 8'd0) begin
      k = ALL_ONES;
    end else if (q == '0) begin
      k = ONE;
    end else begin
      k = q;
    end
    return k;
  endfunction

  k_divider #(
    .W  (W),
    .DW (8)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (w_start),
    .dividend (DIVIDEND),
    .divisor  (r_n_q),
    .busy     (w_div_busy),
    .done     (w_div_done),
    .quotient (w_quotient)
  );

  // Decode controller request and decide when a finished K is captured
  always_comb begin
    w_calc   = (bus.cur_state == ST_CALC_K);
    w_start  = (r_dstate == D_IDLE) && w_calc;
    w_k_load = (r_dstate == D_BUSY) && w_calc && w_div_busy && w_div_done;
    w_k_new  = clamp_k(r_n_q, w_quotient);
  end

  // Divider sequencing; leaving CALC_K at any point returns to idle
  always_comb begin
    w_dstate_next = r_dstate;
    case (r_dstate)
      D_IDLE: begin
        if (w_calc) begin
          w_dstate_next = D_BUSY;
        end else begin
          w_dstate_next = D_IDLE;
        end
      end
      D_BUSY: begin
        if (!w_calc) begin
          w_dstate_next = D_IDLE;
        end else if (w_k_load) begin
          w_dstate_next = D_DONE;
        end else begin
          w_dstate_next = D_BUSY;
        end
      end
      D_DONE: begin
        if (!w_calc) begin
          w_dstate_next = D_IDLE;
        end else begin
          w_dstate_next = D_DONE;
        end
      end
      default: begin
        w_dstate_next = D_IDLE;
      end
    endcase
  end

  // Divider state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dstate <= D_IDLE;
    end else begin
      r_dstate <= w_dstate_next;
    end
  end

  // Divisor is sampled only when a division starts; later switch changes wait
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_n_q <= 8'd0;
    end else if (w_start) begin
      r_n_q <= bus.n_in;
    end
  end

  // K is updated only by a completed division; aborts leave it untouched
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_k_out <= ONE;
    end else if (w_k_load) begin
      r_k_out <= w_k_new;
    end
  end

  // Period counter: load with -K so terminal count lands K increments later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (bus.LdCnt) begin
      r_cnt <= ~r_k_out + ONE;
    end else if (bus.counten) begin
      r_cnt <= r_cnt + ONE;
    end
  end

  assign w_cout = bus.counten && (r_cnt == ALL_ONES);

  // Square wave toggles on each enabled terminal count, held low when disabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wave <= 1'b0;
    end else if (!bus.valid) begin
      r_wave <= 1'b0;
    end else if (w_cout) begin
      r_wave <= ~r_wave;
    end
  end

  assign bus.kcalc = (r_dstate == D_DONE) && w_calc;
  assign bus.cout  = w_cout;
  assign bus.k_out = r_k_out;
  assign bus.wave  = r_wave;

endmodule
